// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM encodings for the AXI4-Lite register file slave.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_HALF = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_reg_bank.sv
// Register storage with byte-strobe merge, read-only gating, write pulses and a flat view.
module axi4_lite_reg_bank #(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter int unsigned         IDX_W      = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           wrEn_i,
  input  logic [IDX_W-1:0]               wrIdx_i,
  input  logic                           wrInRange_i,
  input  logic [DATA_WIDTH-1:0]          wrData_i,
  input  logic [DATA_WIDTH/8-1:0]        wrStrb_i,
  output logic                           wrOk_o,
  input  logic [IDX_W-1:0]               rdIdx_i,
  output logic [DATA_WIDTH-1:0]          rdData_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wrPulse_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q;

  // An error commit (out of range or read-only) must neither change storage nor pulse.
  assign wrOk_o    = wrInRange_i && !RO_MASK[wrIdx_i];
  assign rdData_o  = regs_q[rdIdx_i];
  assign wrPulse_o = pulse_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (wrEn_i && wrOk_o) begin
        for (int k = 0; k < BYTES; k++) begin
          if (wrStrb_i[k]) regs_q[wrIdx_i][k*8 +: 8] <= wrData_i[k*8 +: 8];
        end
        pulse_q[wrIdx_i] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gFlat
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave with independent AW/W capture, one outstanding write and one outstanding read.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr_in,
  input  logic [2:0]                     awprot_in,
  input  logic                           awvalid_in,
  output logic                           awready_out,
  input  logic [DATA_WIDTH-1:0]          wdata_in,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_in,
  input  logic                           wvalid_in,
  output logic                           wready_out,
  output logic [1:0]                     bresp_out,
  output logic                           bvalid_out,
  input  logic                           bready_in,
  input  logic [ADDR_WIDTH-1:0]          araddr_in,
  input  logic [2:0]                     arprot_in,
  input  logic                           arvalid_in,
  output logic                           arready_out,
  output logic [DATA_WIDTH-1:0]          rdata_out,
  output logic [1:0]                     rresp_out,
  output logic                           rvalid_out,
  input  logic                           rready_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic [NUM_REGS-1:0]            wr_pulse_out
);

  localparam int unsigned         BYTES      = DATA_WIDTH / 8;
  localparam int unsigned         LSB        = $clog2(BYTES);
  localparam int unsigned         IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(NUM_REGS * BYTES);

  wr_state_e wrState_q, wrState_d;
  rd_state_e rdState_q, rdState_d;
  logic      started_q;

  logic                  awHave_q, wHave_q;
  logic [ADDR_WIDTH-1:0] awAddr_q;
  logic [DATA_WIDTH-1:0] wData_q;
  logic [BYTES-1:0]      wStrb_q;
  logic [1:0]            bResp_q, rResp_q;
  logic [DATA_WIDTH-1:0] rData_q;

  logic                  awHs, wHs, arHs, commit;
  logic [ADDR_WIDTH-1:0] cmtAddr;
  logic [DATA_WIDTH-1:0] cmtData;
  logic [BYTES-1:0]      cmtStrb;
  logic [IDX_W-1:0]      cmtIdx, rdIdx;
  logic                  cmtInRange, cmtOk, rdInRange;
  logic [DATA_WIDTH-1:0] rdRegData;
  logic                  unusedProt;

  assign unusedProt = ^{awprot_in, arprot_in};

  // started_q holds the readies low through reset and lets them rise on the first free edge.
  assign awready_out = started_q && (wrState_q != W_RESP) && !awHave_q;
  assign wready_out  = started_q && (wrState_q != W_RESP) && !wHave_q;
  assign arready_out = started_q && (rdState_q == R_IDLE);
  assign bvalid_out  = (wrState_q == W_RESP);
  assign bresp_out   = bResp_q;
  assign rvalid_out  = (rdState_q == R_DATA);
  assign rdata_out   = rData_q;
  assign rresp_out   = rResp_q;

  assign awHs = awvalid_in && awready_out;
  assign wHs  = wvalid_in && wready_out;
  assign arHs = arvalid_in && arready_out;

  // A live handshake takes precedence over the captured half when forming the commit.
  assign cmtAddr    = awHs ? awaddr_in : awAddr_q;
  assign cmtData    = wHs ? wdata_in : wData_q;
  assign cmtStrb    = wHs ? wstrb_in : wStrb_q;
  assign cmtIdx     = cmtAddr[LSB +: IDX_W];
  assign cmtInRange = ({1'b0, cmtAddr} < ADDR_LIMIT);
  assign rdIdx      = araddr_in[LSB +: IDX_W];
  assign rdInRange  = ({1'b0, araddr_in} < ADDR_LIMIT);

  always_comb begin
    wrState_d = wrState_q;
    commit    = 1'b0;
    case (wrState_q)
      W_IDLE: begin
        if (awHs && wHs) begin
          commit    = 1'b1;
          wrState_d = W_RESP;
        end else if (awHs || wHs) begin
          wrState_d = W_HALF;
        end
      end
      W_HALF: begin
        if ((awHave_q || awHs) && (wHave_q || wHs)) begin
          commit    = 1'b1;
          wrState_d = W_RESP;
        end
      end
      W_RESP: if (bready_in) wrState_d = W_IDLE;
      default: wrState_d = W_IDLE;
    endcase
  end

  always_comb begin
    rdState_d = rdState_q;
    case (rdState_q)
      R_IDLE:  if (arHs) rdState_d = R_DATA;
      R_DATA:  if (rready_in) rdState_d = R_IDLE;
      default: rdState_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wrState_q <= W_IDLE;
      rdState_q <= R_IDLE;
      started_q <= 1'b0;
    end else begin
      wrState_q <= wrState_d;
      rdState_q <= rdState_d;
      started_q <= 1'b1;
    end
  end

  // Half-captured AW or W lives here until its partner arrives; reset discards it.
  always_ff @(posedge aclk) begin
    if (areset) begin
      awHave_q <= 1'b0;
      wHave_q  <= 1'b0;
      awAddr_q <= '0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      bResp_q  <= RESP_OKAY;
    end else if (commit) begin
      awHave_q <= 1'b0;
      wHave_q  <= 1'b0;
      bResp_q  <= cmtOk ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (awHs) begin
        awHave_q <= 1'b1;
        awAddr_q <= awaddr_in;
      end
      if (wHs) begin
        wHave_q <= 1'b1;
        wData_q <= wdata_in;
        wStrb_q <= wstrb_in;
      end
    end
  end

  // Read data is sampled from storage before a same-edge write lands.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rData_q <= '0;
      rResp_q <= RESP_OKAY;
    end else if (arHs) begin
      rData_q <= rdInRange ? rdRegData : '0;
      rResp_q <= rdInRange ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi4_lite_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W),
    .RO_MASK    (RO_MASK)
  ) uRegBank (
    .clk_i       (aclk),
    .reset_i     (areset),
    .wrEn_i      (commit),
    .wrIdx_i     (cmtIdx),
    .wrInRange_i (cmtInRange),
    .wrData_i    (cmtData),
    .wrStrb_i    (cmtStrb),
    .wrOk_o      (cmtOk),
    .rdIdx_i     (rdIdx),
    .rdData_o    (rdRegData),
    .regs_o      (regs_out),
    .wrPulse_o   (wr_pulse_out)
  );

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Directed bench for the AXI4-Lite register file: 32-bit, 16 registers, register 15 read-only.
module tb_axi4_lite_slave_regfile;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   awaddr, wdata, araddr;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic [511:0]  regsOut;
  logic [15:0]   wrPulse;

  logic [31:0]   expRegs [16];
  int            checks   = 0;
  int            failures = 0;

  always #5 aclk = ~aclk;

  axi4_lite_slave_regfile #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (16),
    .RO_MASK    (16'h8000)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .awaddr_in    (awaddr),
    .awprot_in    (awprot),
    .awvalid_in   (awvalid),
    .awready_out  (awready),
    .wdata_in     (wdata),
    .wstrb_in     (wstrb),
    .wvalid_in    (wvalid),
    .wready_out   (wready),
    .bresp_out    (bresp),
    .bvalid_out   (bvalid),
    .bready_in    (bready),
    .araddr_in    (araddr),
    .arprot_in    (arprot),
    .arvalid_in   (arvalid),
    .arready_out  (arready),
    .rdata_out    (rdata),
    .rresp_out    (rresp),
    .rvalid_out   (rvalid),
    .rready_in    (rready),
    .regs_out     (regsOut),
    .wr_pulse_out (wrPulse)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] flatModel();
    logic [511:0] flat;
    for (int i = 0; i < 16; i++) flat[i*32 +: 32] = expRegs[i];
    return flat;
  endfunction

  task automatic checkRegs(input string tag);
    checkOutput(tag, regsOut, flatModel());
  endtask

  // Same-edge AW+W write followed by an immediate B handshake.
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic [1:0] expResp, input logic [15:0] expPulse);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    checkOutput({tag, ".bvalid"}, 512'(bvalid), 512'(1'b1));
    checkOutput({tag, ".bresp"}, 512'(bresp), 512'(expResp));
    checkOutput({tag, ".pulse"}, 512'(wrPulse), 512'(expPulse));
    checkOutput({tag, ".readiesLow"}, 512'({awready, wready}), 512'(2'b00));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    checkOutput({tag, ".bvalidDone"}, 512'(bvalid), 512'(1'b0));
    checkOutput({tag, ".pulseDone"}, 512'(wrPulse), 512'(16'h0));
    checkOutput({tag, ".readiesBack"}, 512'({awready, wready}), 512'(2'b11));
  endtask

  task automatic applyReadStimulus(input string tag, input logic [31:0] addr,
                                   input logic [31:0] expData, input logic [1:0] expResp);
    araddr = addr; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    checkOutput({tag, ".rvalid"}, 512'(rvalid), 512'(1'b1));
    checkOutput({tag, ".rdata"}, 512'(rdata), 512'(expData));
    checkOutput({tag, ".rresp"}, 512'(rresp), 512'(expResp));
    checkOutput({tag, ".arreadyLow"}, 512'(arready), 512'(1'b0));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checkOutput({tag, ".rvalidDone"}, 512'(rvalid), 512'(1'b0));
    checkOutput({tag, ".arreadyBack"}, 512'(arready), 512'(1'b1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    areset = 1'b1;
    awaddr = '0; wdata = '0; araddr = '0; awprot = 3'd0; arprot = 3'd0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 16; i++) expRegs[i] = 32'h0;

    tick();
    tick();
    checkOutput("reset.readies", 512'({awready, wready, arready}), 512'(3'b000));
    checkOutput("reset.valids", 512'({bvalid, rvalid}), 512'(2'b00));
    checkOutput("reset.pulse", 512'(wrPulse), 512'(16'h0));
    checkRegs("reset.regs");
    areset = 1'b0;
    tick();
    checkOutput("release.readies", 512'({awready, wready, arready}), 512'(3'b111));

    applyStimulus("t1.write", 32'h10, 32'hF0B4A596, 4'hF, OKAY, 16'h0010);
    expRegs[4] = 32'hF0B4A596;
    checkRegs("t1.regs");
    applyReadStimulus("t1.read", 32'h10, 32'hF0B4A596, OKAY);

    wdata = 32'hFFFFFFFF; wstrb = 4'b1011; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checkOutput("t2.wreadyLow", 512'(wready), 512'(1'b0));
      checkOutput("t2.awreadyHigh", 512'(awready), 512'(1'b1));
      checkOutput("t2.noBvalid", 512'(bvalid), 512'(1'b0));
      tick();
    end
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    expRegs[4] = 32'hFFB4FFFF;
    checkOutput("t2.bvalid", 512'(bvalid), 512'(1'b1));
    checkOutput("t2.bresp", 512'(bresp), 512'(OKAY));
    checkOutput("t2.pulse", 512'(wrPulse), 512'(16'h0010));
    checkRegs("t2.regs");
    bready = 1'b1;
    tick();
    bready = 1'b0;

    applyStimulus("t3.outOfRange", 32'h40, 32'h12345678, 4'hF, SLVERR, 16'h0);
    checkRegs("t3.regsOor");
    applyStimulus("t3.readOnly", 32'h3C, 32'h87654321, 4'hF, SLVERR, 16'h0);
    checkRegs("t3.regsRo");

    applyReadStimulus("t4.readOor", 32'h44, 32'h0, SLVERR);

    awaddr = 32'h04; wdata = 32'hA5A5A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h10; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    expRegs[1] = 32'hA5A5A5A5;
    checkOutput("t5.pulse", 512'(wrPulse), 512'(16'h0002));
    for (int c = 0; c < 5; c++) begin
      checkOutput("t5.valids", 512'({bvalid, rvalid}), 512'(2'b11));
      checkOutput("t5.bresp", 512'(bresp), 512'(OKAY));
      checkOutput("t5.rdata", 512'(rdata), 512'(32'hFFB4FFFF));
      checkOutput("t5.readies", 512'({awready, wready, arready}), 512'(3'b000));
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    checkOutput("t5.valsDone", 512'({bvalid, rvalid}), 512'(2'b00));
    checkRegs("t5.regs");

    applyStimulus("t6a.prime", 32'h08, 32'h11111111, 4'hF, OKAY, 16'h0004);
    expRegs[2] = 32'h11111111;
    awaddr = 32'h08; wdata = 32'h22222222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h08; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    expRegs[2] = 32'h22222222;
    checkOutput("t6a.rdataOld", 512'(rdata), 512'(32'h11111111));
    checkOutput("t6a.valids", 512'({bvalid, rvalid}), 512'(2'b11));
    checkOutput("t6a.pulse", 512'(wrPulse), 512'(16'h0004));
    checkRegs("t6a.regs");
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    applyReadStimulus("t6a.readNew", 32'h08, 32'h22222222, OKAY);

    wdata = 32'h33333333; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checkOutput("t6b.half", 512'({awready, wready}), 512'(2'b10));
    awaddr = 32'h0C; awvalid = 1'b1; areset = 1'b1;
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < 16; i++) expRegs[i] = 32'h0;
    checkOutput("t6b.resetReadies", 512'({awready, wready, arready}), 512'(3'b000));
    checkOutput("t6b.resetBvalid", 512'(bvalid), 512'(1'b0));
    checkOutput("t6b.resetPulse", 512'(wrPulse), 512'(16'h0));
    checkRegs("t6b.resetRegs");
    areset = 1'b0;
    tick();
    checkOutput("t6b.readiesBack", 512'({awready, wready, arready}), 512'(3'b111));
    checkOutput("t6b.noBvalid", 512'(bvalid), 512'(1'b0));
    checkOutput("t6b.noPulse", 512'(wrPulse), 512'(16'h0));
    applyReadStimulus("t6b.readReg3", 32'h0C, 32'h0, OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
